// File: rtl/spi_multi_cntrl.sv
// Multi-mode, multi-chip-select SPI controller with CS-held bursts.
// Define SPI_LSB_FIRST_EN to shift words LSB first (default MSB first).
module spi_multi_cntrl #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CS         = 1,
    localparam int CSW           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_to_send,
    input  logic [1:0]            spi_mode,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  hold_cs,
    input  logic                  SPI_MISO,
    output logic [DATA_WIDTH-1:0] data_received,
    output logic                  busy,
    output logic                  done,
    output logic                  SPI_SCLK,
    output logic                  SPI_MOSI,
    output logic [NUM_CS-1:0]     SPI_CS
);
    localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW   = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] HMAX      = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_EDGE = BW'(2 * DATA_WIDTH - 1);

    generate
        if (HALF < 2) begin : g_bad_half
            $error("spi_multi_cntrl: CLK_FREQUENCY/(2*SCLK_FREQUENCY) must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TAIL, HOLD} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         edge_cnt;
    logic                  cpol, cpha;
    logic [DATA_WIDTH-1:0] tx, rx;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return w[0];
    endfunction
    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return {1'b0, w[DATA_WIDTH-1:1]};
    endfunction
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w, input logic b);
        return {b, w[DATA_WIDTH-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return w[DATA_WIDTH-1];
    endfunction
    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return {w[DATA_WIDTH-2:0], 1'b0};
    endfunction
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w, input logic b);
        return {w[DATA_WIDTH-2:0], b};
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            edge_cnt      <= '0;
            cpol          <= 1'b0;
            cpha          <= 1'b0;
            tx            <= '0;
            rx            <= '0;
            data_received <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            SPI_SCLK      <= 1'b0;
            SPI_MOSI      <= 1'b0;
            SPI_CS        <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cpol     <= spi_mode[1];
                    cpha     <= spi_mode[0];
                    SPI_SCLK <= spi_mode[1];
                    SPI_CS   <= ~(NUM_CS'(1) << cs_sel);
                    // CPHA=0 must present the first bit before the first edge
                    tx       <= spi_mode[0] ? data_to_send : shift_out(data_to_send);
                    SPI_MOSI <= spi_mode[0] ? 1'b0 : first_bit(data_to_send);
                    busy     <= 1'b1;
                    cnt      <= '0;
                    edge_cnt <= '0;
                    state    <= LEAD;
                end
                LEAD: begin
                    if (cnt == HMAX) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                XFER: begin
                    if (cnt == HMAX) begin
                        cnt      <= '0;
                        SPI_SCLK <= ~SPI_SCLK;
                        edge_cnt <= edge_cnt + BW'(1);
                        // even edge_cnt is a leading edge; sampling side depends on CPHA
                        if ((edge_cnt[0] == 1'b0) ^ cpha) begin
                            rx <= shift_in(rx, SPI_MISO);
                        end else if (edge_cnt != LAST_EDGE) begin
                            SPI_MOSI <= first_bit(tx);
                            tx       <= shift_out(tx);
                        end
                        if (edge_cnt == LAST_EDGE) state <= TAIL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TAIL: begin
                    if (cnt == HMAX) begin
                        cnt           <= '0;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        data_received <= rx;
                        if (hold_cs) begin
                            state <= HOLD;
                        end else begin
                            SPI_CS   <= '1;
                            SPI_MOSI <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (start) begin
                        tx       <= cpha ? data_to_send : shift_out(data_to_send);
                        SPI_MOSI <= cpha ? 1'b0 : first_bit(data_to_send);
                        busy     <= 1'b1;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        state    <= XFER;
                    end else if (!hold_cs) begin
                        SPI_CS   <= '1;
                        SPI_MOSI <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
